// File: rtl/seg7_pkg.sv
// Shared constants and types for reading back the scanned 7-segment display bus.
package seg7_pkg;

   // Glyphs are active-low {a,b,c,d,e,f,g,dp}; dp must stay dark (1).
   localparam logic [7:0] SEG_0     = 8'h03;
   localparam logic [7:0] SEG_1     = 8'h9F;
   localparam logic [7:0] SEG_2     = 8'h25;
   localparam logic [7:0] SEG_3     = 8'h0D;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h49;
   localparam logic [7:0] SEG_6     = 8'h41;
   localparam logic [7:0] SEG_7     = 8'h1F;
   localparam logic [7:0] SEG_8     = 8'h01;
   localparam logic [7:0] SEG_9     = 8'h09;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [3:0] AN_M10   = 4'b0111;
   localparam logic [3:0] AN_M1    = 4'b1011;
   localparam logic [3:0] AN_S10   = 4'b1101;
   localparam logic [3:0] AN_S1    = 4'b1110;
   localparam logic [3:0] AN_BLANK = 4'b1111;

   typedef enum logic [1:0] {
      ERR_TIMEOUT = 2'd0,
      ERR_ANODE   = 2'd1,
      ERR_GLYPH   = 2'd2,
      ERR_RANGE   = 2'd3
   } err_t;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   function automatic logic [5:0] bcd_pair(input logic [3:0] tens, input logic [3:0] ones);
      return 6'(tens) * 6'd10 + 6'(ones);
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps an active-low segment pattern back to its BCD digit; anything else is invalid.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [7:0] seg,
   output logic       valid,
   output logic [3:0] bcd
);

   always_comb begin
      valid = 1'b1;
      bcd   = 4'd0;
      case (seg)
         SEG_0:   bcd = 4'd0;
         SEG_1:   bcd = 4'd1;
         SEG_2:   bcd = 4'd2;
         SEG_3:   bcd = 4'd3;
         SEG_4:   bcd = 4'd4;
         SEG_5:   bcd = 4'd5;
         SEG_6:   bcd = 4'd6;
         SEG_7:   bcd = 4'd7;
         SEG_8:   bcd = 4'd8;
         SEG_9:   bcd = 4'd9;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples the multiplexed seg/an bus, qualifies digits by stability and assembles MM:SS frames.
//
// state   | meaning
// IDLE    | no digits held; waiting for the first valid digit
// COLLECT | partial frame in shadow; inter-digit timeout running
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 4096
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] digits,
   output logic [5:0]  minute,
   output logic [5:0]  second,
   output logic        frame_valid,
   output logic        frame_error,
   output logic [1:0]  err_code
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [3:0]      an_q;
   logic [7:0]      seg_q;
   logic [SW-1:0]   stab_cnt;
   logic            accept;
   logic            same;

   state_t          state, state_n;
   logic [3:0]      mask, mask_n;
   logic [3:0][3:0] shadow, shadow_n;
   logic [TW-1:0]   tmo_cnt, tmo_n;
   err_t            err_q, err_n;
   logic            load, err;

   logic            dec_valid;
   logic [3:0]      dec_bcd;
   logic            an_legal;
   logic [1:0]      idx;
   logic            blank, digit_ok, acc_err, tmo_hit;
   err_t            acc_code;

   assign same = (an == an_q) && (seg == seg_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         an_q     <= AN_BLANK;
         seg_q    <= SEG_BLANK;
         stab_cnt <= '0;
         accept   <= 1'b0;
      end else begin
         an_q   <= an;
         seg_q  <= seg;
         accept <= same && (stab_cnt == SW'(STABLE_CYCLES - 1));
         if (!same)
            stab_cnt <= SW'(1);
         else if (stab_cnt != SW'(STABLE_CYCLES))
            stab_cnt <= stab_cnt + SW'(1);
      end
   end

   seg7_glyph_decode u_decode (
      .seg   (seg_q),
      .valid (dec_valid),
      .bcd   (dec_bcd)
   );

   always_comb begin
      an_legal = 1'b1;
      idx      = 2'd0;
      case (an_q)
         AN_M10:  idx = 2'd3;
         AN_M1:   idx = 2'd2;
         AN_S10:  idx = 2'd1;
         AN_S1:   idx = 2'd0;
         default: an_legal = 1'b0;
      endcase
   end

   // Tens positions sit at odd indices (m10=3, s10=1) and may only hold 0..5.
   assign blank    = (an_q == AN_BLANK);
   assign digit_ok = accept && !blank && an_legal && dec_valid && !(idx[0] && (dec_bcd > 4'd5));
   assign acc_err  = accept && !blank && !digit_ok;
   assign acc_code = !an_legal ? ERR_ANODE : (!dec_valid ? ERR_GLYPH : ERR_RANGE);
   assign tmo_hit  = (state == COLLECT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_n  = state;
      mask_n   = mask;
      shadow_n = shadow;
      tmo_n    = '0;
      err_n    = err_q;
      load     = 1'b0;
      err      = 1'b0;
      if (state == COLLECT)
         tmo_n = tmo_cnt + TW'(1);
      if (digit_ok) begin
         shadow_n[idx] = dec_bcd;
         mask_n[idx]   = 1'b1;
         tmo_n         = '0;
         state_n       = COLLECT;
      end else if (acc_err) begin
         err   = 1'b1;
         err_n = acc_code;
      end else if (tmo_hit) begin
         err   = 1'b1;
         err_n = ERR_TIMEOUT;
      end
      // A completed mask publishes on the same edge that stores the last digit.
      if (err || (mask_n == 4'b1111)) begin
         load    = !err;
         mask_n  = 4'b0000;
         tmo_n   = '0;
         state_n = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mask        <= 4'b0000;
         shadow      <= '0;
         tmo_cnt     <= '0;
         err_q       <= ERR_TIMEOUT;
         digits      <= 16'h0000;
         minute      <= 6'd0;
         second      <= 6'd0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_n;
         mask        <= mask_n;
         shadow      <= shadow_n;
         tmo_cnt     <= tmo_n;
         err_q       <= err_n;
         frame_valid <= load;
         frame_error <= err;
         if (load) begin
            digits <= shadow_n;
            minute <= bcd_pair(shadow_n[3], shadow_n[2]);
            second <= bcd_pair(shadow_n[1], shadow_n[0]);
         end
      end
   end

   assign err_code = err_q;

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
Reader for the multiplexed 4-digit 7-segment display bus (seg/an) that the stopwatch drives. It samples the scanned anode and segment lines and qualifies each digit by stability. It decodes glyphs back to BCD and assembles complete MM:SS frames. Used as an on-chip self-check / readback path and as a bench monitor for display-producing blocks.

Parameters:
STABLE_CYCLES, 16, consecutive identical {an,seg} samples required before a digit is accepted (>=2)
TIMEOUT_CYCLES, 4096, max cycles between accepted digits of a partial frame before it is discarded

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
seg  input  8  segment lines {a,b,c,d,e,f,g,dp}, active-low
an  input  4  anode lines, active-low one-hot; an[3]=minute tens, an[2]=minute ones, an[1]=second tens, an[0]=second ones
digits  output  16  last complete frame {m10,m1,s10,s1}, 4-bit BCD each
minute  output  6  m10*10+m1, range 0..59
second  output  6  s10*10+s1, range 0..59
frame_valid  output  1  one-cycle pulse when digits/minute/second update
frame_error  output  1  one-cycle pulse on a discarded digit or frame
err_code  output  2  cause of most recent error; held until next error

Behaviour:
- Reset (sync, active-high) values: digits=0, minute=0, second=0, frame_valid=0, frame_error=0, err_code=0. Also: sample regs an=4'b1111, seg=8'hFF, stability count 0, seen-mask 0, timeout count 0, state IDLE.
- Sample stage: one register stage on {an,seg}.
- Stability counter:
  - Sample differs from previous sample -> count:=1.
  - Sample equals previous sample -> count increments, saturating at STABLE_CYCLES.
  - accept fires for exactly one cycle, when count transitions to STABLE_CYCLES.
  - No re-accept until the sample changes.
- Accept classification, in priority order:
  - an=4'b1111 (blank): ignored silently; no error.
  - an not in {0111,1011,1101,1110}: error, err_code=1 (illegal anode).
  - seg not a legal glyph: error, err_code=2 (bad glyph).
  - Legal glyphs, dp bit must be 1: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09 (hex).
  - Decoded value >5 on a tens position (an[3] or an[1]): error, err_code=3 (range).
  - Otherwise: valid digit; write nibble into shadow[idx] and set mask[idx]. If the bit is already set, the latest value overwrites.
- Frame FSM:
  - IDLE (mask==0): on a valid digit -> COLLECT.
  - COLLECT: when mask becomes 4'b1111:
    - On the next edge, digits/minute/second load from shadow and frame_valid pulses 1 cycle.
    - mask clears; FSM -> IDLE.
- Error handling:
  - Any error clears mask, returns FSM to IDLE, pulses frame_error 1 cycle, and loads err_code.
  - Outputs digits/minute/second are unchanged on error.
- Timeout:
  - In COLLECT, the counter increments each cycle without a valid accept and resets to 0 on a valid accept.
  - Reaching TIMEOUT_CYCLES -> error with err_code=0, mask cleared, FSM -> IDLE.
  - Accept and timeout in the same cycle: accept wins.
- Latency:
  - {an,seg} change presented before edge t is sampled at t.
  - accept is asserted during cycle t+STABLE_CYCLES-1.
  - Outputs/pulses register on edge t+STABLE_CYCLES.
- Arithmetic: minute/second use a 4x4 multiply-by-10 plus add, 6-bit result. Max legal value is 59; no wrap is possible.
- Reset mid-frame: partial frame dropped; no pulse is generated.

Decomposition:
- Package seg7_pkg:
  - Glyph constants SEG_0..SEG_9 and SEG_BLANK=8'hFF.
  - Anode constants AN_M10=4'b0111, AN_M1=4'b1011, AN_S10=4'b1101, AN_S1=4'b1110.
  - err_code enum: ERR_TIMEOUT=0, ERR_ANODE=1, ERR_GLYPH=2, ERR_RANGE=3.
  - FSM state enum {IDLE, COLLECT}.
- Sub-module seg7_glyph_decode: combinational seg[7:0] -> {valid, bcd[3:0]}. It is shared with any future display monitors.

Test Plan:
- Static display:
  - Stimulus: scan "12:34" with each digit held 20 cycles in order an 0111/9F, 1011/25, 1101/0D, 1110/99, repeated.
  - Required: frame_valid pulses once per scan; digits=16'h1234, minute=12, second=34.
- Glitch rejection:
  - Stimulus: insert a 5-cycle seg=0x01 glitch mid-digit.
  - Required: no accept of 8 and no error; frame still 12:34.
- Bad glyph:
  - Stimulus: an=1110, seg=0xFE held 20 cycles.
  - Required: frame_error pulse, err_code=2, outputs still hold the previous frame.
- Range error:
  - Stimulus: an=1101, seg=0x41 (6) held 20 cycles.
  - Required: frame_error pulse, err_code=3.
- Timeout:
  - Stimulus: accept m10 only, then hold an=1111 for 4200 cycles.
  - Required: frame_error pulse 4096 cycles after the accept, err_code=0, no frame_valid.
- Reset mid-frame:
  - Stimulus: accept 3 digits, assert Reset for 1 cycle, then present only s1.
  - Required: no frame_valid; all outputs 0; a subsequent full scan "59:59" yields minute=59, second=59.
